// File: rtl/ifu_pipe_pkg.sv
// Shared core package for the instruction fetch unit.
// Holds the IFU parameter defaults, the IFQ entry type and a depth helper
// used to size the in-order request-address FIFO.
package ifu_pipe_pkg;

  localparam int unsigned IfqDepthDefault       = 4;
  localparam int unsigned MaxOutstandingDefault = 2;
  localparam logic [31:0] ResetPcDefault        = 32'h0000_0000;

  // One fetched instruction together with the address it was fetched from.
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } ifq_entry_t;

  // Smallest power of two that is >= n and >= 2. The FIFO pointer scheme
  // (extra wrap bit) only works for power-of-two depths of at least 2.
  function automatic int unsigned fifo_depth(int unsigned n);
    int unsigned d;
    d = 2;
    for (int i = 0; i < 31; i++) begin
      if (d < n) d = d << 1;
    end
    return d;
  endfunction

endpackage

// File: rtl/ifu_fifo.sv
// Synchronous first-word-fall-through FIFO with a synchronous clear.
// Ports:
//   clk, rst_n      clock and synchronous active-low reset (pointers only)
//   clr             drop all entries; wins over a same-cycle write or read
//   wr_en, wr_data  push (accepted when not full, or when full and popping)
//   rd_en           pop the head (ignored while empty)
//   rd_data         current head, valid whenever empty is low
//   empty, full     status flags
//   count           number of stored entries
module ifu_fifo #(
  parameter int unsigned Width = 32,
  parameter int unsigned Depth = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     wr_en,
  input  logic [Width-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [Width-1:0]         rd_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(Depth):0]   count
);

  localparam int unsigned Aw = $clog2(Depth);

  // Pointers carry one extra wrap bit so full and empty can be told apart.
  logic [Aw:0]      wptr_q, wptr_d;
  logic [Aw:0]      rptr_q, rptr_d;
  logic [Width-1:0] mem_q [Depth];
  logic             do_wr;
  logic             do_rd;

  always_comb begin
    empty   = (wptr_q == rptr_q);
    full    = (wptr_q[Aw] != rptr_q[Aw]) && (wptr_q[Aw-1:0] == rptr_q[Aw-1:0]);
    count   = wptr_q - rptr_q;
    rd_data = mem_q[rptr_q[Aw-1:0]];

    do_rd   = rd_en & ~empty & ~clr;
    do_wr   = wr_en & (~full | do_rd) & ~clr;

    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    if (clr) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (do_wr) wptr_d = wptr_q + 1'b1;
      if (do_rd) rptr_d = rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wptr_q[Aw-1:0]] <= wr_data;
  end

endmodule

// File: rtl/ifu_pipe.sv
// Instruction fetch unit: issues pipelined Avalon reads, queues the returned
// instructions in the IFQ and presents the head to decode.
// Ports:
//   clk, rst_n                         clock, synchronous active-low reset
//   redirect_valid, redirect_pc        flush the IFQ and restart fetch
//   instruction, instruction_pc        IFQ head (first-word-fall-through)
//   instruction_valid/_ready           head handshake towards decode
//   ibus_read, ibus_address            read request, held under waitrequest
//   ibus_waitrequest                   request not accepted this cycle
//   ibus_readdatavalid, ibus_readdata  in-order read response
module ifu_pipe
  import ifu_pipe_pkg::*;
#(
  parameter int unsigned IFQ_DEPTH       = IfqDepthDefault,
  parameter int unsigned MAX_OUTSTANDING = MaxOutstandingDefault,
  parameter logic [31:0] RESET_PC        = ResetPcDefault
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] instruction,
  output logic [31:0] instruction_pc,
  output logic        instruction_valid,
  input  logic        instruction_ready,
  output logic        ibus_read,
  output logic [31:0] ibus_address,
  input  logic        ibus_waitrequest,
  input  logic        ibus_readdatavalid,
  input  logic [31:0] ibus_readdata
);

  localparam int unsigned CntW        = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned IfqAw       = $clog2(IFQ_DEPTH);
  localparam int unsigned PcFifoDepth = fifo_depth(MAX_OUTSTANDING);
  localparam int unsigned PcFifoAw    = $clog2(PcFifoDepth);

  logic [31:0]     pc_q, pc_d;
  logic            held_q, held_d;        // request stalled by waitrequest
  logic [CntW-1:0] out_q, out_d;          // accepted, not yet returned
  logic [CntW-1:0] drop_q, drop_d;        // responses still owed to old path
  logic            pend_q, pend_d;        // redirect waiting on a held request
  logic [31:0]     pend_pc_q, pend_pc_d;

  logic            accept;
  logic            credit_ok;
  logic [31:0]     redirect_pc_al;

  logic            ifq_wr_en;
  logic            ifq_rd_en;
  ifq_entry_t      ifq_wr_data;
  ifq_entry_t      ifq_rd_data;
  logic            ifq_empty;
  logic            ifq_full;
  logic [IfqAw:0]  ifq_count;

  logic [31:0]     pcf_head;
  logic            pcf_empty;
  logic            pcf_full;
  logic [PcFifoAw:0] pcf_count;

  // ---------------------------------------------------------------------------
  // Request side
  // ---------------------------------------------------------------------------
  always_comb begin
    redirect_pc_al = {redirect_pc[31:2], 2'b00};

    // Only issue when every in-flight response is guaranteed an IFQ slot.
    credit_ok = (32'(out_q) < MAX_OUTSTANDING) &&
                ((32'(ifq_count) + 32'(out_q)) < IFQ_DEPTH);

    ibus_read    = rst_n & (held_q | credit_ok);
    ibus_address = pc_q;
    accept       = ibus_read & ~ibus_waitrequest;
    held_d       = ibus_read & ibus_waitrequest;

    unique case ({accept, ibus_readdatavalid})
      2'b10:   out_d = out_q + 1'b1;
      2'b01:   out_d = out_q - 1'b1;
      default: out_d = out_q;
    endcase
  end

  // ---------------------------------------------------------------------------
  // PC, drop counter and pending redirect
  // ---------------------------------------------------------------------------
  always_comb begin
    pc_d      = pc_q;
    drop_d    = drop_q;
    pend_d    = pend_q;
    pend_pc_d = pend_pc_q;

    if (ibus_readdatavalid && (drop_q != '0)) drop_d = drop_q - 1'b1;

    if (accept) begin
      pc_d = pc_q + 32'd4;
      if (pend_q) begin
        // The held request belonged to the old path: retarget and owe a drop.
        pc_d   = pend_pc_q;
        pend_d = 1'b0;
        drop_d = drop_d + 1'b1;
      end
    end

    if (redirect_valid) begin
      drop_d = out_d;
      if (held_d) begin
        // Address must stay stable until accept; apply the redirect after it.
        pc_d      = pc_q;
        pend_d    = 1'b1;
        pend_pc_d = redirect_pc_al;
      end else begin
        pc_d      = redirect_pc_al;
        pend_d    = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q      <= RESET_PC;
      held_q    <= 1'b0;
      out_q     <= '0;
      drop_q    <= '0;
      pend_q    <= 1'b0;
      pend_pc_q <= '0;
    end else begin
      pc_q      <= pc_d;
      held_q    <= held_d;
      out_q     <= out_d;
      drop_q    <= drop_d;
      pend_q    <= pend_d;
      pend_pc_q <= pend_pc_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Request-address FIFO: pairs each in-order response with its address
  // ---------------------------------------------------------------------------
  ifu_fifo #(
    .Width (32),
    .Depth (PcFifoDepth)
  ) u_pc_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (1'b0),
    .wr_en   (accept),
    .wr_data (pc_q),
    .rd_en   (ibus_readdatavalid),
    .rd_data (pcf_head),
    .empty   (pcf_empty),
    .full    (pcf_full),
    .count   (pcf_count)
  );

  // ---------------------------------------------------------------------------
  // Instruction fetch queue
  // ---------------------------------------------------------------------------
  always_comb begin
    ifq_wr_en         = ibus_readdatavalid & (drop_q == '0);
    ifq_wr_data.instr = ibus_readdata;
    ifq_wr_data.pc    = pcf_head;

    instruction_valid = rst_n & ~ifq_empty & ~redirect_valid;
    instruction       = ifq_rd_data.instr;
    instruction_pc    = ifq_rd_data.pc;
    ifq_rd_en         = instruction_valid & instruction_ready;
  end

  ifu_fifo #(
    .Width ($bits(ifq_entry_t)),
    .Depth (IFQ_DEPTH)
  ) u_ifq (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (redirect_valid),
    .wr_en   (ifq_wr_en),
    .wr_data (ifq_wr_data),
    .rd_en   (ifq_rd_en),
    .rd_data (ifq_rd_data),
    .empty   (ifq_empty),
    .full    (ifq_full),
    .count   (ifq_count)
  );

  logic unused_sigs;
  assign unused_sigs = ^{redirect_pc[1:0], pcf_empty, pcf_full, pcf_count, ifq_full};

endmodule

// File: tb/tb_ifu_pipe.sv
// Directed bench for ifu_pipe with a small Avalon responder whose response
// latency and waitrequest are set per step. Instruction data returned by the
// responder is the bitwise inverse of the fetch address.
module tb_ifu_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] instruction;
  logic [31:0] instruction_pc;
  logic        instruction_valid;
  logic        instruction_ready;
  logic        ibus_read;
  logic [31:0] ibus_address;
  logic        ibus_waitrequest;
  logic        ibus_readdatavalid;
  logic [31:0] ibus_readdata;

  int unsigned n_checks = 0;
  int unsigned n_err    = 0;

  always #5 clk = ~clk;

  ifu_pipe dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .redirect_valid     (redirect_valid),
    .redirect_pc        (redirect_pc),
    .instruction        (instruction),
    .instruction_pc     (instruction_pc),
    .instruction_valid  (instruction_valid),
    .instruction_ready  (instruction_ready),
    .ibus_read          (ibus_read),
    .ibus_address       (ibus_address),
    .ibus_waitrequest   (ibus_waitrequest),
    .ibus_readdatavalid (ibus_readdatavalid),
    .ibus_readdata      (ibus_readdata)
  );

  // Bus responder: an accepted read returns lat_m1+1 cycles later.
  logic [1:0]  lat_m1;
  logic        wreq;
  logic [3:0]  dv;
  logic [31:0] da [4];

  assign ibus_waitrequest   = wreq;
  assign ibus_readdatavalid = dv[0];
  assign ibus_readdata      = ~da[0];

  always @(posedge clk) begin
    if (!rst_n) begin
      dv <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        dv[i] <= dv[i+1];
        da[i] <= da[i+1];
      end
      dv[3] <= 1'b0;
      if (ibus_read && !ibus_waitrequest) begin
        dv[lat_m1] <= 1'b1;
        da[lat_m1] <= ibus_address;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int unsigned max_cycles, input string tag);
    int unsigned k;
    k = 0;
    while (instruction_valid !== 1'b1 && k < max_cycles) begin
      tick();
      k++;
    end
    n_checks++;
    assert (instruction_valid === 1'b1)
    else begin
      n_err++;
      $error("FAIL %s: instruction_valid observed %b expected 1 within %0d cycles",
             tag, instruction_valid, max_cycles);
    end
  endtask

  // Reset for two edges, then release; returns just after the release.
  task automatic do_reset(input logic [1:0] lm1, input logic rdy);
    rst_n             = 1'b0;
    lat_m1            = lm1;
    wreq              = 1'b0;
    redirect_valid    = 1'b0;
    redirect_pc       = 32'h0;
    instruction_ready = rdy;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n             = 1'b0;
    lat_m1            = 2'd0;
    wreq              = 1'b0;
    redirect_valid    = 1'b0;
    redirect_pc       = 32'h0;
    instruction_ready = 1'b1;
    tick();
    tick();

    // Reset state.
    chk("reset_read", {31'h0, ibus_read}, 32'h0);
    chk("reset_valid", {31'h0, instruction_valid}, 32'h0);
    chk("reset_addr", ibus_address, 32'h0);

    // Zero-wait bus, decode always ready: first instruction on cycle 3.
    rst_n = 1'b1;
    #1;
    chk("c1_read", {31'h0, ibus_read}, 32'h1);
    chk("c1_addr", ibus_address, 32'h0);
    tick();
    chk("c2_addr", ibus_address, 32'h4);
    chk("c2_valid", {31'h0, instruction_valid}, 32'h0);
    tick();
    chk("c3_valid", {31'h0, instruction_valid}, 32'h1);
    chk("c3_pc", instruction_pc, 32'h0);
    chk("c3_instr", instruction, ~32'h0);
    tick();
    chk("c4_pc", instruction_pc, 32'h4);
    tick();
    chk("c5_pc", instruction_pc, 32'h8);

    // Decode stalls: fetch stops once the queue plus in-flight reads fill it.
    instruction_ready = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    chk("stall_read", {31'h0, ibus_read}, 32'h0);
    chk("stall_addr", ibus_address, 32'h18);
    chk("stall_head", instruction_pc, 32'h8);
    instruction_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      chk("resume_valid", {31'h0, instruction_valid}, 32'h1);
      chk("resume_pc", instruction_pc, 32'h8 + 32'(4 * i));
      tick();
    end

    // Three-cycle latency, two reads in flight, redirect (low bits ignored).
    do_reset(2'd2, 1'b1);
    tick();
    tick();
    chk("lat3_credit_read", {31'h0, ibus_read}, 32'h0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0103;
    tick();
    redirect_valid = 1'b0;
    chk("lat3_redir_addr", ibus_address, 32'h100);
    wait_valid(30, "lat3_wait");
    chk("lat3_pc0", instruction_pc, 32'h100);
    chk("lat3_instr0", instruction, ~32'h100);
    tick();
    chk("lat3_pc1", instruction_pc, 32'h104);

    // Redirect while a request is held under waitrequest.
    do_reset(2'd0, 1'b0);
    tick();
    tick();
    wreq = 1'b1;
    #1;
    chk("hold_read", {31'h0, ibus_read}, 32'h1);
    chk("hold_addr", ibus_address, 32'h8);
    chk("hold_head", instruction_pc, 32'h0);
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    #1;
    chk("hold_redir_valid", {31'h0, instruction_valid}, 32'h0);
    chk("hold_redir_addr", ibus_address, 32'h8);
    tick();
    redirect_valid = 1'b0;
    #1;
    chk("hold_after_read", {31'h0, ibus_read}, 32'h1);
    chk("hold_after_addr", ibus_address, 32'h8);
    chk("hold_flushed", {31'h0, instruction_valid}, 32'h0);
    tick();
    chk("hold_still_addr", ibus_address, 32'h8);
    wreq = 1'b0;
    tick();
    chk("hold_new_addr", ibus_address, 32'h200);
    instruction_ready = 1'b1;
    wait_valid(20, "hold_wait");
    chk("hold_first_pc", instruction_pc, 32'h200);
    chk("hold_first_instr", instruction, ~32'h200);

    // Back-to-back redirects: the later one wins.
    do_reset(2'd0, 1'b1);
    for (int i = 0; i < 5; i++) tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h300;
    tick();
    redirect_pc = 32'h400;
    #1;
    chk("b2b_addr", ibus_address, 32'h300);
    tick();
    redirect_valid = 1'b0;
    wait_valid(20, "b2b_wait");
    chk("b2b_pc0", instruction_pc, 32'h400);
    tick();
    chk("b2b_pc1", instruction_pc, 32'h404);

    // Reset in the middle of two outstanding reads.
    do_reset(2'd2, 1'b1);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_read", {31'h0, ibus_read}, 32'h0);
    chk("mid_rst_valid", {31'h0, instruction_valid}, 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    chk("post_rst_valid", {31'h0, instruction_valid}, 32'h0);
    chk("post_rst_addr", ibus_address, 32'h0);
    wait_valid(30, "post_rst_wait");
    chk("post_rst_pc", instruction_pc, 32'h0);
    chk("post_rst_instr", instruction, ~32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/ifu_pipe.md
IFU_PIPE -- requirements
Module: ifu_pipe

Interface
REQ-001 SHALL have parameter IFQ_DEPTH, default 4, instruction fetch queue entries (power of two, >=2).
REQ-002 SHALL have parameter MAX_OUTSTANDING, default 2, accepted-but-unreturned ibus reads (1..IFQ_DEPTH).
REQ-003 SHALL have parameter RESET_PC, default 32'h0, first fetch address.
REQ-004 SHALL use one clock; reset is synchronous and active-low.
REQ-005 clk  in  1  clock.
REQ-006 rst_n  in  1  synchronous active-low reset.
REQ-007 redirect_valid  in  1  flush IFQ and restart fetch (taken branch or trap, merged by HDU).
REQ-008 redirect_pc  in  32  new fetch address; bits [1:0] are ignored and treated as 0.
REQ-009 instruction / instruction_pc  out  32 / 32  IFQ head, first-word-fall-through.
REQ-010 instruction_valid  out  1  IFQ non-empty and no redirect this cycle.
REQ-011 instruction_ready  in  1  decode accepts head; fire = valid & ready.
REQ-012 ibus_read / ibus_address  out  1 / 32  pipelined Avalon read request.
REQ-013 ibus_waitrequest  in  1  request not accepted this cycle.
REQ-014 ibus_readdatavalid / ibus_readdata  in  1 / 32  in-order read response.

Function
REQ-015 ibus accept = ibus_read & ~ibus_waitrequest; read, address SHALL stay stable while waitrequest=1.
REQ-016 ibus_read SHALL be 1 when reset is deasserted, outstanding < MAX_OUTSTANDING, and occupancy + outstanding < IFQ_DEPTH (credit check: every response has a slot).
REQ-017 Once asserted with waitrequest=1, ibus_read SHALL stay 1 until accept regardless of credit or redirect.
REQ-018 pc SHALL increment by 4 on accept; a small in-order PC FIFO (MAX_OUTSTANDING deep) SHALL pair each response with its request address.
REQ-019 outstanding counter: +1 on accept, -1 on readdatavalid, unchanged when both occur in the same cycle; width $clog2(MAX_OUTSTANDING+1).
REQ-020 Response with drop_cnt==0 SHALL be written to IFQ as {readdata, pc}; with drop_cnt>0 it SHALL be discarded and drop_cnt decremented.
REQ-021 On redirect_valid: IFQ pointers cleared; drop_cnt <= outstanding (counted after this cycle's accept and return); instruction_valid forced 0 that cycle.
REQ-022 On redirect with no request held under waitrequest, pc <= redirect_pc next cycle; otherwise the held request SHALL complete, its response SHALL be dropped (drop_cnt += 1 on accept), and pc <= redirect_pc on the cycle after that accept (pending redirect register).
REQ-023 A later redirect SHALL overwrite a pending redirect (last wins).
REQ-024 IFQ write and read of a non-empty queue SHALL occur in the same cycle without loss; a write to an empty queue SHALL be visible at the head the next cycle.
REQ-025 Pointers SHALL be AWIDTH+1 bits; full = MSB differs with equal low bits; pointers wrap modulo 2*IFQ_DEPTH.
REQ-026 Fetch-to-output latency SHALL be 1 cycle after readdatavalid (zero-wait bus gives 2 cycles from accept).
REQ-027 With ready=1 and zero-wait bus, sustained throughput SHALL be 1 instruction/cycle when MAX_OUTSTANDING>=2.

Reset
REQ-028 In reset: pc=RESET_PC, ibus_read=0, instruction_valid=0, pointers, outstanding, drop_cnt, pending redirect = 0.
REQ-029 Reset asserted mid-transaction SHALL abandon outstanding reads; the bus is reset together with this block.
REQ-030 The IFQ and PC-FIFO data arrays SHALL NOT be reset.

Structure
REQ-031 IFU parameter defaults and an ifq_entry_t {instr, pc} typedef SHALL reside in the shared core package.
REQ-032 The IFQ SHALL be one sub-module, ifu_fifo (parametrised width/depth, FWFT, clear input), instantiated for the IFQ and the PC FIFO.

Verification
REQ-033 Zero-wait bus, ready=1, after reset -> first valid with pc=0x0 on cycle 3, then 0x4, 0x8 on consecutive cycles.
REQ-034 ready=0 for 20 cycles -> ibus_read drops once occupancy+outstanding=4; no overflow; on resume, pc order is 0x0,0x4,... with no gaps.
REQ-035 Bus with 3-cycle response latency, 2 reads in flight, redirect to 0x100 -> both in-flight responses dropped; next valid pc=0x100.
REQ-036 waitrequest=1 held at address 0x8 while redirect to 0x200 -> address stays 0x8 until accept, that response is dropped, next request address 0x200.
REQ-037 Redirects to 0x300 then 0x400 on consecutive cycles -> no 0x300 output; first valid pc=0x400.
REQ-038 rst_n low during 2 outstanding reads, then released -> instruction_valid=0, first fetch at RESET_PC, stale responses absent.
